// File: rtl/axil_timeout_pkg.sv
// Shared constants and FSM encodings for the AXI4-lite watchdog.
package axil_timeout_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {WrIdle, WrReq, WrResp, WrBresp, WrTo, WrDrain} wr_state_e;
   typedef enum logic [2:0] {RdIdle, RdReq, RdResp, RdData, RdTo, RdDrain} rd_state_e;

   // Saturating increment for the optional 16-bit timeout event counters.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/axil_timeout_cnt.sv
// Clear/enable saturating cycle counter; expired is high once the count reaches TIMEOUT-1,
// i.e. in the last cycle a transaction is allowed to complete normally.
module axil_timeout_cnt #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   // Count cycles spent waiting; clear has priority, hold at TIMEOUT.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != CW'(TIMEOUT))) begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

   assign expired = (cnt_q >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/axil_timeout.sv
// Per-lane AXI4-lite watchdog. Forwards one write and one read at a time; a transaction the
// slave does not finish within TIMEOUT cycles is answered upstream with SLVERR and the late
// downstream transaction is drained silently. Optional macro AXIL_TIMEOUT_COUNT_EN adds
// 16-bit saturating timeout event counters.
module axil_timeout
   import axil_timeout_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   input  logic [2:0]            s_axil_awprot,
   input  logic                  s_axil_awvalid,
   output logic                  s_axil_awready,
   input  logic [DATA_WIDTH-1:0] s_axil_wdata,
   input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
   input  logic                  s_axil_wvalid,
   output logic                  s_axil_wready,
   output logic [1:0]            s_axil_bresp,
   output logic                  s_axil_bvalid,
   input  logic                  s_axil_bready,
   input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
   input  logic [2:0]            s_axil_arprot,
   input  logic                  s_axil_arvalid,
   output logic                  s_axil_arready,
   output logic [DATA_WIDTH-1:0] s_axil_rdata,
   output logic [1:0]            s_axil_rresp,
   output logic                  s_axil_rvalid,
   input  logic                  s_axil_rready,
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready,
`ifdef AXIL_TIMEOUT_COUNT_EN
   output logic [15:0]           wr_timeout_count,
   output logic [15:0]           rd_timeout_count,
`endif
   output logic                  wr_timeout,
   output logic                  rd_timeout
);

   wr_state_e wr_state_q, wr_state_d;
   rd_state_e rd_state_q, rd_state_d;

   // *_held: captured upstream and not yet accepted downstream; doubles as m_*valid.
   logic aw_held_q, aw_held_d, w_held_q, w_held_d, b_seen_q, b_seen_d;
   logic ar_held_q, ar_held_d, r_seen_q, r_seen_d;
   logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
   logic [2:0] awprot_q, arprot_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic wr_clr, wr_en, wr_expired, wr_fire, wr_timeout_q;
   logic rd_clr, rd_en, rd_expired, rd_fire, rd_timeout_q;

   logic s_aw_hs, s_w_hs, s_ar_hs, m_aw_hs, m_w_hs, m_b_hs, m_ar_hs, m_r_hs;
   logic wr_fwd, rd_fwd;

   assign wr_fwd = (wr_state_q == WrReq) || (wr_state_q == WrTo) || (wr_state_q == WrDrain);
   assign rd_fwd = (rd_state_q == RdReq) || (rd_state_q == RdTo) || (rd_state_q == RdDrain);

   assign s_axil_awready = (wr_state_q == WrIdle) && !aw_held_q && !rst;
   assign s_axil_wready  = (wr_state_q == WrIdle) && !w_held_q && !rst;
   assign s_axil_arready = (rd_state_q == RdIdle) && !ar_held_q && !rst;
   assign s_axil_bvalid  = (wr_state_q == WrBresp) || (wr_state_q == WrTo);
   assign s_axil_bresp   = (wr_state_q == WrBresp) ? bresp_q :
                           (wr_state_q == WrTo) ? RESP_SLVERR : RESP_OKAY;
   assign s_axil_rvalid  = (rd_state_q == RdData) || (rd_state_q == RdTo);
   assign s_axil_rresp   = (rd_state_q == RdData) ? rresp_q :
                           (rd_state_q == RdTo) ? RESP_SLVERR : RESP_OKAY;
   assign s_axil_rdata   = (rd_state_q == RdData) ? rdata_q : '0;

   assign m_axil_awaddr  = awaddr_q;
   assign m_axil_awprot  = awprot_q;
   assign m_axil_awvalid = aw_held_q && wr_fwd;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_wvalid  = w_held_q && wr_fwd;
   assign m_axil_araddr  = araddr_q;
   assign m_axil_arprot  = arprot_q;
   assign m_axil_arvalid = ar_held_q && rd_fwd;
   // After a timeout, accept exactly one late response and then stop.
   assign m_axil_bready  = (wr_state_q == WrReq) || (wr_state_q == WrResp) ||
                           (((wr_state_q == WrTo) || (wr_state_q == WrDrain)) && !b_seen_q);
   assign m_axil_rready  = (rd_state_q == RdReq) || (rd_state_q == RdResp) ||
                           (((rd_state_q == RdTo) || (rd_state_q == RdDrain)) && !r_seen_q);

   assign s_aw_hs = s_axil_awvalid && s_axil_awready;
   assign s_w_hs  = s_axil_wvalid && s_axil_wready;
   assign s_ar_hs = s_axil_arvalid && s_axil_arready;
   assign m_aw_hs = m_axil_awvalid && m_axil_awready;
   assign m_w_hs  = m_axil_wvalid && m_axil_wready;
   assign m_b_hs  = m_axil_bvalid && m_axil_bready;
   assign m_ar_hs = m_axil_arvalid && m_axil_arready;
   assign m_r_hs  = m_axil_rvalid && m_axil_rready;

   assign wr_timeout = wr_timeout_q;
   assign rd_timeout = rd_timeout_q;

   axil_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_wr_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (wr_clr),
      .en      (wr_en),
      .expired (wr_expired)
   );

   axil_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_rd_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (rd_clr),
      .en      (rd_en),
      .expired (rd_expired)
   );

   // Capture request payloads on the upstream handshakes.
   always_ff @(posedge clk) begin
      if (rst) begin
         awaddr_q <= '0;
         awprot_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         araddr_q <= '0;
         arprot_q <= '0;
      end else begin
         if (s_aw_hs) begin
            awaddr_q <= s_axil_awaddr;
            awprot_q <= s_axil_awprot;
         end
         if (s_w_hs) begin
            wdata_q <= s_axil_wdata;
            wstrb_q <= s_axil_wstrb;
         end
         if (s_ar_hs) begin
            araddr_q <= s_axil_araddr;
            arprot_q <= s_axil_arprot;
         end
      end
   end

   // State, pending flags, latched responses and registered timeout pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q   <= WrIdle;
         rd_state_q   <= RdIdle;
         aw_held_q    <= 1'b0;
         w_held_q     <= 1'b0;
         b_seen_q     <= 1'b0;
         ar_held_q    <= 1'b0;
         r_seen_q     <= 1'b0;
         bresp_q      <= '0;
         rresp_q      <= '0;
         rdata_q      <= '0;
         wr_timeout_q <= 1'b0;
         rd_timeout_q <= 1'b0;
      end else begin
         wr_state_q   <= wr_state_d;
         rd_state_q   <= rd_state_d;
         aw_held_q    <= aw_held_d;
         w_held_q     <= w_held_d;
         b_seen_q     <= b_seen_d;
         ar_held_q    <= ar_held_d;
         r_seen_q     <= r_seen_d;
         bresp_q      <= bresp_d;
         rresp_q      <= rresp_d;
         rdata_q      <= rdata_d;
         wr_timeout_q <= wr_fire;
         rd_timeout_q <= rd_fire;
      end
   end

   // Write FSM next state; a response seen in the expiring cycle beats the timeout.
   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      b_seen_d   = b_seen_q;
      bresp_d    = bresp_q;
      wr_clr     = 1'b0;
      wr_en      = 1'b0;
      wr_fire    = 1'b0;
      if (s_aw_hs) aw_held_d = 1'b1;
      if (s_w_hs)  w_held_d  = 1'b1;
      if (m_aw_hs) aw_held_d = 1'b0;
      if (m_w_hs)  w_held_d  = 1'b0;
      if (m_b_hs)  b_seen_d  = 1'b1;
      unique case (wr_state_q)
         WrIdle: begin
            if (aw_held_d && w_held_d) begin
               wr_state_d = WrReq;
               wr_clr     = 1'b1;
               b_seen_d   = 1'b0;
            end
         end
         WrReq: begin
            wr_en = 1'b1;
            if (m_b_hs) bresp_d = m_axil_bresp;
            if (!aw_held_d && !w_held_d && b_seen_d) begin
               wr_state_d = WrBresp;
            end else if (wr_expired) begin
               wr_state_d = WrTo;
               wr_fire    = 1'b1;
            end else if (!aw_held_d && !w_held_d) begin
               wr_state_d = WrResp;
            end
         end
         WrResp: begin
            wr_en = 1'b1;
            if (m_b_hs) begin
               bresp_d    = m_axil_bresp;
               wr_state_d = WrBresp;
            end else if (wr_expired) begin
               wr_state_d = WrTo;
               wr_fire    = 1'b1;
            end
         end
         WrBresp: if (s_axil_bready) wr_state_d = WrIdle;
         WrTo:    if (s_axil_bready) wr_state_d = WrDrain;
         WrDrain: if (!aw_held_d && !w_held_d && b_seen_d) wr_state_d = WrIdle;
         default: wr_state_d = WrIdle;
      endcase
   end

   // Read FSM next state; mirrors the write side with a single address channel.
   always_comb begin
      rd_state_d = rd_state_q;
      ar_held_d  = ar_held_q;
      r_seen_d   = r_seen_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      rd_clr     = 1'b0;
      rd_en      = 1'b0;
      rd_fire    = 1'b0;
      if (s_ar_hs) ar_held_d = 1'b1;
      if (m_ar_hs) ar_held_d = 1'b0;
      if (m_r_hs)  r_seen_d  = 1'b1;
      unique case (rd_state_q)
         RdIdle: begin
            if (ar_held_d) begin
               rd_state_d = RdReq;
               rd_clr     = 1'b1;
               r_seen_d   = 1'b0;
            end
         end
         RdReq, RdResp: begin
            rd_en = 1'b1;
            if (m_r_hs) begin
               rresp_d = m_axil_rresp;
               rdata_d = m_axil_rdata;
            end
            if (!ar_held_d && r_seen_d) begin
               rd_state_d = RdData;
            end else if (rd_expired) begin
               rd_state_d = RdTo;
               rd_fire    = 1'b1;
            end else if (!ar_held_d) begin
               rd_state_d = RdResp;
            end
         end
         RdData:  if (s_axil_rready) rd_state_d = RdIdle;
         RdTo:    if (s_axil_rready) rd_state_d = RdDrain;
         RdDrain: if (!ar_held_d && r_seen_d) rd_state_d = RdIdle;
         default: rd_state_d = RdIdle;
      endcase
   end

`ifdef AXIL_TIMEOUT_COUNT_EN
   // Saturating timeout event counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_timeout_count <= '0;
         rd_timeout_count <= '0;
      end else begin
         if (wr_fire) wr_timeout_count <= sat_inc16(wr_timeout_count);
         if (rd_fire) rd_timeout_count <= sat_inc16(rd_timeout_count);
      end
   end
`endif

endmodule

// File: tb/tb_axil_timeout.sv
// Directed self-checking bench for axil_timeout with TIMEOUT = 16. Inputs are driven and
// outputs sampled on the falling edge; the DUT acts on the rising edge.
module tb_axil_timeout;

   localparam int unsigned TO = 16;

   logic clk = 1'b0;
   logic rst;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [2:0]  s_awprot, s_arprot;
   logic [3:0]  s_wstrb;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic [1:0]  s_bresp, s_rresp;
   logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
   logic [2:0]  m_awprot, m_arprot;
   logic [3:0]  m_wstrb;
   logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
   logic        m_arvalid, m_arready, m_rvalid, m_rready;
   logic [1:0]  m_bresp, m_rresp;
   logic        wr_timeout, rd_timeout;
`ifdef AXIL_TIMEOUT_COUNT_EN
   logic [15:0] wr_timeout_count, rd_timeout_count;
`endif

   int errs = 0;
   int checks = 0;
   int wr_pulses = 0;
   int rd_pulses = 0;

   always #5 clk = ~clk;

   axil_timeout #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid),
      .s_axil_awready(s_awready), .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb),
      .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready), .s_axil_bresp(s_bresp),
      .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready), .s_axil_araddr(s_araddr),
      .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
      .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid),
      .s_axil_rready(s_rready),
      .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
      .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
      .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
      .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready), .m_axil_araddr(m_araddr),
      .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
      .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
      .m_axil_rready(m_rready),
`ifdef AXIL_TIMEOUT_COUNT_EN
      .wr_timeout_count(wr_timeout_count), .rd_timeout_count(rd_timeout_count),
`endif
      .wr_timeout(wr_timeout), .rd_timeout(rd_timeout)
   );

   // Count timeout pulses, one sample per cycle.
   always @(negedge clk) begin
      if (wr_timeout) wr_pulses++;
      if (rd_timeout) rd_pulses++;
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic put_aw_w(input logic [31:0] addr, input logic [31:0] data);
      s_awaddr = addr; s_awprot = 3'b010; s_awvalid = 1'b1;
      s_wdata = data; s_wstrb = 4'hF; s_wvalid = 1'b1;
   endtask

   // Normal write: B returned bdly cycles after the forward cycle; response one cycle later.
   task automatic wr_ok(input logic [31:0] addr, input logic [31:0] data, input int bdly,
                        input logic [1:0] resp);
      @(negedge clk); put_aw_w(addr, data);
      @(negedge clk); s_awvalid = 1'b0; s_wvalid = 1'b0;
      check_eq("wr_fwd_awvalid", m_awvalid, 1);
      check_eq("wr_fwd_wvalid", m_wvalid, 1);
      check_eq("wr_fwd_addr", m_awaddr, addr);
      check_eq("wr_fwd_data", m_wdata, data);
      check_eq("wr_fwd_prot_strb", {m_awprot, m_wstrb}, {3'b010, 4'hF});
      repeat (bdly) @(negedge clk);
      m_bvalid = 1'b1; m_bresp = resp;
      @(negedge clk); m_bvalid = 1'b0;
      check_eq("wr_bvalid", s_bvalid, 1);
      check_eq("wr_bresp", s_bresp, resp);
      @(negedge clk);
      check_eq("wr_bvalid_done", s_bvalid, 0);
   endtask

   initial begin
      rst = 1'b1;
      s_awaddr = '0; s_awprot = '0; s_awvalid = 0; s_wdata = '0; s_wstrb = '0; s_wvalid = 0;
      s_bready = 1; s_araddr = '0; s_arprot = '0; s_arvalid = 0; s_rready = 1;
      m_awready = 1; m_wready = 1; m_bresp = '0; m_bvalid = 0; m_arready = 1;
      m_rdata = '0; m_rresp = '0; m_rvalid = 0;

      // Reset values.
      @(negedge clk);
      check_eq("rst_readies", {s_awready, s_wready, s_arready}, 3'b000);
      check_eq("rst_valids", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}, 5'b0);
      check_eq("rst_mready", {m_bready, m_rready}, 2'b00);
      rst = 1'b0;
      @(negedge clk);
      check_eq("post_rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
      check_eq("post_rst_resp_data", {s_bresp, s_rresp, s_rdata}, 36'h0);
      check_eq("post_rst_pulses", {wr_timeout, rd_timeout}, 2'b00);

      // Normal write, B OKAY three cycles after forwarding.
      wr_ok(32'h10, 32'hDEADBEEF, 3, 2'b00);
      check_eq("normal_no_pulse", wr_pulses, 0);

      // Write timeout: slave accepts AW/W, never answers; upstream holds off bready.
      s_bready = 1'b0;
      @(negedge clk); put_aw_w(32'h20, 32'h11112222);
      @(negedge clk); s_awvalid = 1'b0; s_wvalid = 1'b0;     // cycle T0
      repeat (TO - 1) @(negedge clk);                         // T0+15
      check_eq("wto_before_bvalid", s_bvalid, 0);
      check_eq("wto_before_pulse", wr_timeout, 0);
      @(negedge clk);                                          // T0+16
      check_eq("wto_bvalid", s_bvalid, 1);
      check_eq("wto_bresp", s_bresp, 2'b10);
      check_eq("wto_pulse", wr_timeout, 1);
      @(negedge clk);
      check_eq("wto_pulse_once", wr_timeout, 0);
      check_eq("wto_bvalid_held", s_bvalid, 1);
      s_bready = 1'b1;
      @(negedge clk);
      check_eq("wto_drain_bvalid", s_bvalid, 0);
      check_eq("wto_drain_busy", s_awready, 0);
      repeat (3) @(negedge clk);
      m_bvalid = 1'b1; m_bresp = 2'b00;
      @(negedge clk); m_bvalid = 1'b0;
      check_eq("wto_late_b_swallowed", s_bvalid, 0);
      check_eq("wto_idle_again", s_awready, 1);
      wr_ok(32'h24, 32'h55AA55AA, 2, 2'b00);

      // Read timeout with arready stalled for 40 cycles.
      m_arready = 1'b0;
      @(negedge clk); s_araddr = 32'h40; s_arprot = 3'b001; s_arvalid = 1'b1;
      @(negedge clk); s_arvalid = 1'b0;                       // cycle T0
      check_eq("rto_arvalid", m_arvalid, 1);
      check_eq("rto_araddr", {m_arprot, m_araddr}, {3'b001, 32'h40});
      repeat (TO) @(negedge clk);                              // T0+16
      check_eq("rto_rvalid", s_rvalid, 1);
      check_eq("rto_rresp", s_rresp, 2'b10);
      check_eq("rto_rdata", s_rdata, 0);
      check_eq("rto_pulse", rd_timeout, 1);
      repeat (TO - 1 - 16 + 40 - TO) @(negedge clk);          // T0+39
      check_eq("rto_rvalid_done", s_rvalid, 0);
      check_eq("rto_arvalid_held", m_arvalid, 1);
      m_arready = 1'b1;
      @(negedge clk);                                          // T0+40
      check_eq("rto_arvalid_drop", m_arvalid, 0);
      check_eq("rto_drain_busy", s_arready, 0);
      m_rvalid = 1'b1; m_rdata = 32'h12345678; m_rresp = 2'b00;
      @(negedge clk); m_rvalid = 1'b0;
      check_eq("rto_late_r_swallowed", s_rvalid, 0);
      check_eq("rto_idle_again", s_arready, 1);

      // Race: B handshake in the last allowed cycle wins over the timeout.
      @(negedge clk); put_aw_w(32'h30, 32'hA5A5A5A5);
      @(negedge clk); s_awvalid = 1'b0; s_wvalid = 1'b0;     // cycle T0
      repeat (TO - 1) @(negedge clk);                         // T0+15
      m_bvalid = 1'b1; m_bresp = 2'b00;
      @(negedge clk); m_bvalid = 1'b0;
      check_eq("race_bvalid", s_bvalid, 1);
      check_eq("race_bresp", s_bresp, 2'b00);
      check_eq("race_no_pulse", wr_timeout, 0);
      @(negedge clk);
      check_eq("race_total_wr_pulses", wr_pulses, 1);

      // Concurrent read and write.
      @(negedge clk); put_aw_w(32'h50, 32'h0BADF00D);
      s_araddr = 32'h60; s_arvalid = 1'b1;
      @(negedge clk); s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      check_eq("conc_fwd", {m_awvalid, m_wvalid, m_arvalid}, 3'b111);
      @(negedge clk);
      m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D; m_rresp = 2'b00;
      @(negedge clk); m_rvalid = 1'b0;
      check_eq("conc_rvalid", s_rvalid, 1);
      check_eq("conc_rdata", s_rdata, 32'hCAFEF00D);
      check_eq("conc_w_pending", s_bvalid, 0);
      m_bvalid = 1'b1; m_bresp = 2'b01;
      @(negedge clk); m_bvalid = 1'b0;
      check_eq("conc_bvalid", s_bvalid, 1);
      check_eq("conc_bresp", s_bresp, 2'b01);
      check_eq("conc_r_done", s_rvalid, 0);
      @(negedge clk);

      // Reset in the middle of WrResp.
      @(negedge clk); put_aw_w(32'h70, 32'h77777777);
      @(negedge clk); s_awvalid = 1'b0; s_wvalid = 1'b0;
      @(negedge clk);
      check_eq("mid_resp_bready", m_bready, 1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_valids", {s_bvalid, s_rvalid, m_awvalid, m_wvalid, m_arvalid}, 5'b0);
      check_eq("mid_rst_mready", {m_bready, m_rready}, 2'b00);
      check_eq("mid_rst_awready", s_awready, 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_idle", {s_awready, s_wready, s_arready, m_bready}, 4'b1110);
      wr_ok(32'h74, 32'h89ABCDEF, 1, 2'b00);

      check_eq("total_wr_pulses", wr_pulses, 1);
      check_eq("total_rd_pulses", rd_pulses, 1);
`ifdef AXIL_TIMEOUT_COUNT_EN
      check_eq("wr_timeout_count", wr_timeout_count, 16'd0);  // cleared by mid-test reset
      check_eq("rd_timeout_count", rd_timeout_count, 16'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
